div_unit: RTL

Iterative 32-cycle restoring divider for the execute stage of the five-stage MIPS pipeline. It serves DIV/DIVU and writes HI/LO. It sits beside the ALU in E and feeds its `ready_o` to the hazard unit, which holds F/D/E stalled while a divide is in E and `ready_o` is low. The exception/flush logic can cancel an operation in flight through `annul_i`.

---
 rtl/div_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU) for the E stage; result is {remainder, quotient}.
// Optional feature macro: DIV_ZERO_FAST_EN (zero divisor completes one cycle after accept).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dividend_raw;
    logic [CW-1:0]    cnt;
    logic             neg_quo;
    logic             neg_rem;
    logic             div_zero;
    logic             ready_q;

    logic             carry;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;

    // The bit shifted out of rem guarantees the trial subtract succeeds; the low
    // WIDTH bits of the difference are then exact because the true result < divisor.
    always_comb begin
        carry   = rem[WIDTH-1];
        diff    = {1'b0, rem[WIDTH-2:0], quo[WIDTH-1]} - {1'b0, dvs};
        take    = carry | ~diff[WIDTH];
        rem_nx  = take ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo_nx  = {quo[WIDTH-2:0], take};
        quo_fix = neg_quo ? -quo_nx : quo_nx;
        rem_fix = neg_rem ? -rem_nx : rem_nx;
        op1_abs = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_abs = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            dividend_raw <= '0;
            cnt          <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            ready_q      <= 1'b0;
            result_o     <= '0;
        end else if (annul_i) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (start_i) begin
                        neg_quo      <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem      <= signed_i & opdata1_i[WIDTH-1];
                        dvs          <= op2_abs;
                        quo          <= op1_abs;
                        rem          <= '0;
                        cnt          <= '0;
                        dividend_raw <= opdata1_i;
                        div_zero     <= (opdata2_i == '0);
`ifdef DIV_ZERO_FAST_EN
                        if (opdata2_i == '0) begin
                            result_o <= {opdata1_i, {WIDTH{1'b1}}};
                            ready_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state    <= DONE;
                        ready_q  <= 1'b1;
                        result_o <= div_zero ? {dividend_raw, {WIDTH{1'b1}}}
                                             : {rem_fix, quo_fix};
                    end
                end
                DONE: begin
                    // start_i is deliberately ignored so the completing divide cannot restart.
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A flush landing in the DONE cycle suppresses the pulse that is already registered.
    assign ready_o = ready_q & ~annul_i;

endmodule
